// File: rtl/rgbled_pkg.sv
// Shared definitions for the RGB LED fade/PWM block.
// Holds the bit offsets of each lane inside a 32-bit per-LED word, the duty
// width, the colour index enum, and a helper that maps a colour index to its
// lane offset.
package rgbled_pkg;

  localparam int WORD_W    = 32;
  localparam int DUTY_W    = 8;
  localparam int RED_LSB   = 24;
  localparam int GREEN_LSB = 16;
  localparam int BLUE_LSB  = 8;
  localparam int STEP_LSB  = 0;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } colour_e;

  // Bit offset of a colour's target byte inside one LED word.
  function automatic int lane_lsb(input int col);
    case (col)
      int'(RED):   lane_lsb = RED_LSB;
      int'(GREEN): lane_lsb = GREEN_LSB;
      int'(BLUE):  lane_lsb = BLUE_LSB;
      default:     lane_lsb = STEP_LSB;
    endcase
  endfunction

endpackage

// File: rtl/rgbled_fade_ch.sv
// One PWM colour channel: target register, current duty register with a
// saturating ramp toward the target, counter compare and registered output.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   enable_i      - global run enable (output forced low when 0)
//   load_i        - capture target_i into the target register
//   boundary_i    - PWM period boundary; the only time cur may move
//   cnt_i         - shared 8-bit PWM counter
//   target_i      - new target duty
//   step_i        - fade step of the owning LED (already registered)
//   pwm_o         - registered PWM output
//   busy_o        - current duty differs from target (combinational)
module rgbled_fade_ch
  import rgbled_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic              boundary_i,
  input  logic [DUTY_W-1:0] cnt_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic              pwm_o,
  output logic              busy_o
);

  logic [DUTY_W-1:0] target_q;
  logic [DUTY_W-1:0] cur_q;
  logic [DUTY_W-1:0] cur_d;
  logic              pwm_q;
  logic [DUTY_W:0]   sum_s;
  logic [DUTY_W:0]   diff_s;

  // Saturating ramp of the current duty; sums are 9 bits so neither direction wraps.
  always_comb begin
    sum_s  = {1'b0, cur_q} + {1'b0, step_i};
    diff_s = {1'b0, cur_q} - {1'b0, step_i};
    cur_d  = cur_q;
    if (boundary_i) begin
      if (step_i == {DUTY_W{1'b0}}) begin
        cur_d = target_q;
      end else if (cur_q < target_q) begin
        if (sum_s >= {1'b0, target_q}) begin
          cur_d = target_q;
        end else begin
          cur_d = sum_s[DUTY_W-1:0];
        end
      end else if (cur_q > target_q) begin
        // diff_s[DUTY_W] set means cur-step went negative
        if (diff_s[DUTY_W] || (diff_s[DUTY_W-1:0] <= target_q)) begin
          cur_d = target_q;
        end else begin
          cur_d = diff_s[DUTY_W-1:0];
        end
      end else begin
        cur_d = cur_q;
      end
    end else begin
      cur_d = cur_q;
    end
  end

  // Target capture, duty update and registered compare output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q <= {DUTY_W{1'b0}};
      cur_q    <= {DUTY_W{1'b0}};
      pwm_q    <= 1'b0;
    end else begin
      if (load_i) begin
        target_q <= target_i;
      end else begin
        target_q <= target_q;
      end
      cur_q <= cur_d;
      pwm_q <= enable_i && (cnt_i < cur_q);
    end
  end

  assign pwm_o  = pwm_q;
  assign busy_o = (cur_q != target_q);

endmodule

// File: rtl/rgbled_fade_pwm.sv
// Multi-LED RGB PWM driver with per-period fading toward programmed targets.
// A shared prescaler and 8-bit counter time the PWM; every period boundary
// each channel steps its duty toward its target.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   led_i                 - per-LED words {red, green, blue, step}
//   led_valid_i           - one-cycle strobe capturing led_i
//   prescale_i            - tick divider (tick every prescale_i+1 cycles)
//   enable_i              - global run enable
//   o_red/o_green/o_blue  - PWM outputs, one bit per LED
//   period_o              - pulse in the first cycle of each period
//   busy_o                - some channel is still fading
module rgbled_fade_pwm
  import rgbled_pkg::*;
#(
  parameter int NLEDS      = 2,
  parameter int PRESCALE_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WORD_W*NLEDS-1:0] led_i,
  input  logic                    led_valid_i,
  input  logic [PRESCALE_W-1:0]   prescale_i,
  input  logic                    enable_i,
  output logic [NLEDS-1:0]        o_red,
  output logic [NLEDS-1:0]        o_green,
  output logic [NLEDS-1:0]        o_blue,
  output logic                    period_o,
  output logic                    busy_o
);

  localparam int NCH = 3 * NLEDS;

  logic [PRESCALE_W-1:0]         presc_q;
  logic [PRESCALE_W-1:0]         presc_d;
  logic [DUTY_W-1:0]             cnt_q;
  logic [DUTY_W-1:0]             cnt_d;
  logic                          period_q;
  logic                          period_d;
  logic                          busy_q;
  logic [NLEDS-1:0][DUTY_W-1:0]  step_q;
  logic                          tick_s;
  logic                          boundary_s;
  logic [NCH-1:0]                pwm_s;
  logic [NCH-1:0]                ch_busy_s;

  // Tick and period-boundary decode from the shared counters.
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    if (enable_i) begin
      tick_s     = (presc_q == prescale_i);
      boundary_s = tick_s && (cnt_q == {DUTY_W{1'b1}});
    end else begin
      tick_s     = 1'b0;
      boundary_s = 1'b0;
    end
  end

  // Next state of prescaler, PWM counter and period pulse.
  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    period_d = 1'b0;
    if (!enable_i) begin
      presc_d = {PRESCALE_W{1'b0}};
      cnt_d   = {DUTY_W{1'b0}};
    end else if (tick_s) begin
      presc_d  = {PRESCALE_W{1'b0}};
      cnt_d    = cnt_q + {{(DUTY_W-1){1'b0}}, 1'b1};
      period_d = boundary_s;
    end else begin
      presc_d = presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  // Shared timing registers and the registered busy reduction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= {PRESCALE_W{1'b0}};
      cnt_q    <= {DUTY_W{1'b0}};
      period_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      busy_q   <= |ch_busy_s;
    end
  end

  // Per-LED fade step capture; a capture on a boundary edge only affects later ramps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_q <= {(NLEDS*DUTY_W){1'b0}};
    end else if (led_valid_i) begin
      for (int l = 0; l < NLEDS; l++) begin
        step_q[l] <= led_i[WORD_W*l+STEP_LSB +: DUTY_W];
      end
    end else begin
      step_q <= step_q;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    localparam int LED = c / 3;
    localparam int LSB = lane_lsb(c % 3);
    rgbled_fade_ch u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_i),
      .load_i     (led_valid_i),
      .boundary_i (boundary_s),
      .cnt_i      (cnt_q),
      .target_i   (led_i[WORD_W*LED+LSB +: DUTY_W]),
      .step_i     (step_q[LED]),
      .pwm_o      (pwm_s[c]),
      .busy_o     (ch_busy_s[c])
    );
  end

  for (genvar l = 0; l < NLEDS; l++) begin : g_led
    assign o_red[l]   = pwm_s[3*l+int'(RED)];
    assign o_green[l] = pwm_s[3*l+int'(GREEN)];
    assign o_blue[l]  = pwm_s[3*l+int'(BLUE)];
  end

  assign period_o = period_q;
  assign busy_o   = busy_q;

endmodule

// File: doc/rgbled_fade_pwm.md
RGBLED_FADE_PWM -- requirements
Module: rgbled_fade_pwm

Interface
REQ-001 SHALL have parameter NLEDS, default 2, giving the number of RGB LEDs.
REQ-002 SHALL have parameter PRESCALE_W, default 16, giving the prescaler width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port led_i, input, 32*NLEDS bits: per-LED word n at [32n+31:32n]; [31:24] red target, [23:16] green target, [15:8] blue target, [7:0] fade step.
REQ-006 SHALL have port led_valid_i, input, 1 bit: a one-cycle strobe that captures led_i.
REQ-007 SHALL have port prescale_i, input, PRESCALE_W bits: PWM tick divider.
REQ-008 SHALL have port enable_i, input, 1 bit: global run enable.
REQ-009 SHALL have ports o_red, o_green and o_blue, outputs, NLEDS bits each: the PWM outputs.
REQ-010 SHALL have port period_o, output, 1 bit: one-cycle pulse at each PWM period start.
REQ-011 SHALL have port busy_o, output, 1 bit: high while any channel's current duty differs from its target.

Function
REQ-012 The prescaler SHALL count 0..prescale_i, assert tick when count==prescale_i, then wrap to 0; prescale_i=0 SHALL tick every cycle; a prescale_i change SHALL apply at the next compare.
REQ-013 The 8-bit PWM counter SHALL increment on tick and wrap 255->0; a period is 256*(prescale_i+1) cycles.
REQ-014 The period boundary SHALL be tick with counter==255; period_o SHALL be registered high for exactly the cycle in which the counter first reads 0 after the wrap.
REQ-015 On led_valid_i, each channel's target register (8 bit) and each LED's step register (8 bit) SHALL load from led_i on that edge.
REQ-016 Current duty (cur) SHALL change only on the period-boundary edge.
REQ-017 At a boundary, if step==0, cur SHALL be set to target.
REQ-018 At a boundary, if cur<target, cur SHALL be set to min(cur+step, target), computed in 9 bits with no wrap.
REQ-019 At a boundary, if cur>target, cur SHALL be set to max(cur-step, target), computed in 9 bits with no underflow.
REQ-020 When led_valid_i coincides with a boundary, the ramp SHALL use the pre-capture target and step; the new values SHALL apply from the next boundary.
REQ-021 Each output SHALL be registered as enable_i AND (counter < cur), giving 1-cycle latency from the counter; cur=0 SHALL give a constantly low output; cur=255 SHALL give high for 255 of 256 counts.
REQ-022 While enable_i=0, the prescaler and PWM counter SHALL be held at 0 and all outputs and period_o SHALL be 0 from the next cycle; cur SHALL hold; targets SHALL still capture.
REQ-023 On enable_i rising, counting SHALL restart from counter=0 with no period_o pulse until the first wrap.
REQ-024 busy_o SHALL be registered as the OR over all 3*NLEDS channels of (cur != target).

Reset
REQ-025 While rst_i=1, the prescaler, counter, cur, target, step, o_red, o_green, o_blue, period_o and busy_o SHALL all be 0 on the next edge, including mid-fade or mid-period.
REQ-026 After rst_i is deasserted, operation SHALL resume from counter=0 per REQ-023 when enable_i=1.

Structure
REQ-027 Shared package rgbled_pkg SHALL hold the lane-offset constants (RED_LSB=24, GREEN_LSB=16, BLUE_LSB=8, STEP_LSB=0), DUTY_W=8, and the colour-index enum (RED, GREEN, BLUE).
REQ-028 Sub-module rgbled_fade_ch SHALL hold one channel's target register, cur register, saturating ramp, compare and output register.
REQ-029 rgbled_fade_ch SHALL be instantiated 3*NLEDS times in a generate loop.
REQ-030 The prescaler, PWM counter, period_o and busy_o reduction SHALL be shared in the top level.

Verification
REQ-031 prescale 0, LED0 red 0x40 step 0, enable -> after the first boundary, o_red[0] is high for 64 of every 256 cycles and period_o pulses every 256 cycles.
REQ-032 Red target 0x10 step 4 from cur 0 -> cur reads 4, 8, 12, 16 at successive boundaries and busy_o falls after the 4th boundary.
REQ-033 cur 0x10, target 0x00, step 0x0A -> cur reads 0x06 then 0x00, with no underflow; a ramp up from cur 0xF8 to target 0xFF with step 0x10 -> cur 0xFF.
REQ-034 prescale 3 -> period_o every 1024 cycles; led_valid_i asserted on a boundary edge -> old target used, new target used at the next boundary.
REQ-035 enable_i dropped mid-period with duty 0xFF -> all outputs 0 the next cycle and counter 0; re-enabled -> duty resumes with the same cur.
REQ-036 rst_i asserted for 1 cycle mid-fade -> all outputs, cur and busy_o read 0 on the next cycle.
